dram_cmd_responder: RTL and testbench
=====================================

Name: dram_cmd_responder

Overview:
- Behavioural DRAM-side endpoint for the command stream our memory controller issues (ACT, PRE, RD, WR, REF).
- Keeps per-bank open/closed state and the open row, and checks every command against DDR timing.
- Flags protocol and timing violations, and returns read-completion beats after CAS latency.
- Sits on the controller's DRAM output as the bench-side responder and checker.

Parameters:
BG_WIDTH, 2, bank-group select width
BANK_WIDTH, 2, bank select width
ROW_WIDTH, 15, row address width
COLUMN_WIDTH, 10, column address width
T_RCD, 24, minimum cycles from ACT to RD/WR on the same bank
T_RP, 24, minimum cycles from PRE to ACT/REF on the same bank
T_RAS, 52, minimum cycles from ACT to PRE on the same bank
T_CCD_L, 8, minimum cycles between column commands in the same bank group
T_CCD_S, 4, minimum cycles between column commands in different bank groups
T_CAS, 24, cycles from an accepted RD to rd_valid
T_RFC, 350, refresh busy duration in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present this cycle; no backpressure
cmd_op  in  3  0=RD 1=WR 2=ACT 3=PRE 4=REF; 5-7 illegal
cmd_bg  in  BG_WIDTH  bank group
cmd_bank  in  BANK_WIDTH  bank
cmd_row  in  ROW_WIDTH  row (ACT; checked on RD/WR)
cmd_col  in  COLUMN_WIDTH  column (RD/WR)
rd_valid  out  1  read completion pulse
rd_bg  out  BG_WIDTH  completing read bank group
rd_bank  out  BANK_WIDTH  completing read bank
rd_col  out  COLUMN_WIDTH  completing read column
viol  out  1  violation pulse
viol_code  out  4  violation cause, valid while viol=1
bank_open  out  2**(BG_WIDTH+BANK_WIDTH)  per-bank active bitmap, index {bg,bank}
refreshing  out  1  tRFC window in progress

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All outputs are 0.
  - All banks are IDLE and all timers read as satisfied.
  - The read pipeline is flushed.
- Reset mid-operation: in-flight reads are discarded and never produce rd_valid.
- Per-bank state machine:
  - IDLE --ACT--> ACTIVE, latching the open row.
  - ACTIVE --PRE--> IDLE.
  - PRE to an IDLE bank is a legal no-op.
- Timing rule: a command N cycles after its constraining command is legal iff N >= T. Constraints:
  - tRCD: ACT to RD/WR, same bank.
  - tRAS: ACT to PRE, same bank.
  - tRP: PRE to ACT, same bank.
  - tCCD_L / tCCD_S: last RD/WR to next RD/WR, chosen by whether the bank group matches.
  - REF needs every bank to have satisfied tRP.
- Counter width is $clog2(T+1). Counters saturate at 0 and never wrap.
- Violation codes (the lowest applicable code is reported):
  - 1: RD/WR to an IDLE bank.
  - 2: RD/WR row differs from the open row.
  - 3: tRCD.
  - 4: tCCD.
  - 5: tRP.
  - 6: tRAS.
  - 7: any command while refreshing, or REF with any bank open or tRP pending.
  - 8: ACT to an ACTIVE bank.
  - 9: illegal opcode.
- Violating commands are dropped: no state, timer or pipeline change.
- viol/viol_code pulse for exactly one cycle, the cycle after the command.
- Accepted RD enters a T_CAS-deep shift pipeline. rd_valid and rd_* appear exactly T_CAS cycles after the RD cycle. One read per cycle maximum, so there is no pipeline collision.
- WR produces no return.
- Accepted REF:
  - refreshing=1 from the next cycle for T_RFC cycles.
  - A command exactly T_RFC cycles after the REF is legal.
- Timers are loaded in the same edge that accepts their command.
- Outputs are registered, so bank_open reflects a command one cycle later.

Test Plan:
1. ACT bg0/b0 row 5 at t0, RD col 3 at t0+24 -> no viol; bank_open[0]=1 at t0+1; rd_valid with bg0/b0/col3 at t0+48.
2. ACT at t0, RD at t0+23 -> viol=1, code 3 at t0+24; no rd_valid ever; RD at t0+24 -> legal.
3. RD bg0/b0 then RD bg0/b1 4 cycles later -> code 4. Repeat with the second RD at bg1 -> legal, two rd_valid pulses 4 apart.
4. PRE at ACT+51 -> code 6; PRE at ACT+52 -> legal, bank_open cleared. ACT at PRE+23 -> code 5; ACT at PRE+24 -> legal.
5. REF with bg1/b2 open -> code 7. Close all banks, wait T_RP, then REF -> refreshing=1 for 350 cycles. ACT at REF+100 -> code 7; ACT at REF+350 -> legal.
6. RD accepted, rst_n pulsed low 10 cycles later -> no rd_valid; bank_open=0 and all outputs 0 during reset; ACT immediately after release -> legal.

Source files
------------

// File: rtl/dram_cmd_responder.sv
// DRAM-side command responder: tracks per-bank open/closed state and DDR timers, flags violations, returns RD beats.
// Latency: viol and bank_open one cycle after the command; rd_valid T_CAS cycles after an accepted RD. No backpressure.
module dram_cmd_responder #(
    parameter int BG_WIDTH     = 2,
    parameter int BANK_WIDTH   = 2,
    parameter int ROW_WIDTH    = 15,
    parameter int COLUMN_WIDTH = 10,
    parameter int T_RCD        = 24,
    parameter int T_RP         = 24,
    parameter int T_RAS        = 52,
    parameter int T_CCD_L      = 8,
    parameter int T_CCD_S      = 4,
    parameter int T_CAS        = 24,
    parameter int T_RFC        = 350
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cmd_valid,
    input  logic [2:0]                           i_cmd_op,
    input  logic [BG_WIDTH-1:0]                  i_cmd_bg,
    input  logic [BANK_WIDTH-1:0]                i_cmd_bank,
    input  logic [ROW_WIDTH-1:0]                 i_cmd_row,
    input  logic [COLUMN_WIDTH-1:0]              i_cmd_col,
    output logic                                 o_rd_valid,
    output logic [BG_WIDTH-1:0]                  o_rd_bg,
    output logic [BANK_WIDTH-1:0]                o_rd_bank,
    output logic [COLUMN_WIDTH-1:0]              o_rd_col,
    output logic                                 o_viol,
    output logic [3:0]                           o_viol_code,
    output logic [2**(BG_WIDTH+BANK_WIDTH)-1:0]  o_bank_open,
    output logic                                 o_refreshing
);

    localparam int BI_W  = BG_WIDTH + BANK_WIDTH;
    localparam int NB    = 1 << BI_W;
    localparam int RCD_W = $clog2(T_RCD + 1);
    localparam int RP_W  = $clog2(T_RP + 1);
    localparam int RAS_W = $clog2(T_RAS + 1);
    localparam int CCD_W = $clog2(T_CCD_L + 1);
    localparam int RFC_W = $clog2(T_RFC + 1);
    localparam int PW    = BI_W + COLUMN_WIDTH;

    // Timers load T-1 at the accepting edge, so "counter == 0" means N >= T cycles elapsed.
    localparam logic [RCD_W-1:0] RCD_LD  = RCD_W'(T_RCD - 1);
    localparam logic [RP_W-1:0]  RP_LD   = RP_W'(T_RP - 1);
    localparam logic [RAS_W-1:0] RAS_LD  = RAS_W'(T_RAS - 1);
    localparam logic [CCD_W-1:0] CCD_LD  = CCD_W'(T_CCD_L - 1);
    localparam logic [CCD_W-1:0] CCD_GAP = CCD_W'(T_CCD_L - T_CCD_S);
    localparam logic [RFC_W-1:0] RFC_LD  = RFC_W'(T_RFC - 1);
    localparam logic [RCD_W-1:0] RCD_ONE = RCD_W'(1);
    localparam logic [RP_W-1:0]  RP_ONE  = RP_W'(1);
    localparam logic [RAS_W-1:0] RAS_ONE = RAS_W'(1);
    localparam logic [CCD_W-1:0] CCD_ONE = CCD_W'(1);
    localparam logic [RFC_W-1:0] RFC_ONE = RFC_W'(1);

    typedef enum logic [2:0] {
        OP_RD  = 3'd0,
        OP_WR  = 3'd1,
        OP_ACT = 3'd2,
        OP_PRE = 3'd3,
        OP_REF = 3'd4
    } op_e;

    logic [NB-1:0]           r_bank_open;
    logic [ROW_WIDTH-1:0]    r_open_row [NB];
    logic [RCD_W-1:0]        r_rcd_cnt  [NB];
    logic [RP_W-1:0]         r_rp_cnt   [NB];
    logic [RAS_W-1:0]        r_ras_cnt  [NB];
    logic [CCD_W-1:0]        r_ccd_cnt;
    logic [BG_WIDTH-1:0]     r_ccd_bg;
    logic [RFC_W-1:0]        r_rfc_cnt;
    logic                    r_refreshing;
    logic                    r_viol;
    logic [3:0]              r_viol_code;
    logic [T_CAS-1:0]        r_pipe_vld;
    logic [PW-1:0]           r_pipe_dat [T_CAS];

    logic [BI_W-1:0]         w_idx;
    logic                    w_open;
    logic                    w_is_col;
    logic                    w_ccd_block;
    logic                    w_rp_pending;
    logic [3:0]              w_code;
    logic                    w_acc;

    assign w_idx    = {i_cmd_bg, i_cmd_bank};
    assign w_open   = r_bank_open[w_idx];
    assign w_is_col = (i_cmd_op == OP_RD) || (i_cmd_op == OP_WR);
    // Same group needs full tCCD_L; a different group only needs tCCD_S of it elapsed.
    assign w_ccd_block = (r_ccd_bg == i_cmd_bg) ? (r_ccd_cnt != '0) : (r_ccd_cnt > CCD_GAP);

    always_comb begin
        w_rp_pending = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (r_rp_cnt[i] != '0) w_rp_pending = 1'b1;
        end
    end

    always_comb begin
        w_code = 4'd0;
        if (i_cmd_valid) begin
            if (w_is_col && !w_open)                                  w_code = 4'd1;
            else if (w_is_col && r_open_row[w_idx] != i_cmd_row)      w_code = 4'd2;
            else if (w_is_col && r_rcd_cnt[w_idx] != '0)              w_code = 4'd3;
            else if (w_is_col && w_ccd_block)                         w_code = 4'd4;
            else if (i_cmd_op == OP_ACT && r_rp_cnt[w_idx] != '0)     w_code = 4'd5;
            else if (i_cmd_op == OP_PRE && w_open && r_ras_cnt[w_idx] != '0) w_code = 4'd6;
            else if (r_rfc_cnt != '0 ||
                     (i_cmd_op == OP_REF && (|r_bank_open || w_rp_pending))) w_code = 4'd7;
            else if (i_cmd_op == OP_ACT && w_open)                    w_code = 4'd8;
            else if (i_cmd_op > OP_REF)                               w_code = 4'd9;
        end
    end

    assign w_acc = i_cmd_valid && (w_code == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_open  <= '0;
            r_ccd_cnt    <= '0;
            r_ccd_bg     <= '0;
            r_rfc_cnt    <= '0;
            r_refreshing <= 1'b0;
            r_viol       <= 1'b0;
            r_viol_code  <= 4'd0;
            r_pipe_vld   <= '0;
            for (int i = 0; i < NB; i++) begin
                r_open_row[i] <= '0;
                r_rcd_cnt[i]  <= '0;
                r_rp_cnt[i]   <= '0;
                r_ras_cnt[i]  <= '0;
            end
            for (int i = 0; i < T_CAS; i++) r_pipe_dat[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (r_rcd_cnt[i] != '0) r_rcd_cnt[i] <= r_rcd_cnt[i] - RCD_ONE;
                if (r_rp_cnt[i]  != '0) r_rp_cnt[i]  <= r_rp_cnt[i]  - RP_ONE;
                if (r_ras_cnt[i] != '0) r_ras_cnt[i] <= r_ras_cnt[i] - RAS_ONE;
            end
            if (r_ccd_cnt != '0) r_ccd_cnt <= r_ccd_cnt - CCD_ONE;
            if (r_rfc_cnt != '0) r_rfc_cnt <= r_rfc_cnt - RFC_ONE;
            r_refreshing <= (r_rfc_cnt != '0);
            r_viol       <= (w_code != 4'd0);
            r_viol_code  <= w_code;

            r_pipe_vld[0] <= w_acc && (i_cmd_op == OP_RD);
            r_pipe_dat[0] <= {i_cmd_bg, i_cmd_bank, i_cmd_col};
            for (int i = 1; i < T_CAS; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end

            if (w_acc) begin
                case (i_cmd_op)
                    OP_RD, OP_WR: begin
                        r_ccd_cnt <= CCD_LD;
                        r_ccd_bg  <= i_cmd_bg;
                    end
                    OP_ACT: begin
                        r_bank_open[w_idx] <= 1'b1;
                        r_open_row[w_idx]  <= i_cmd_row;
                        r_rcd_cnt[w_idx]   <= RCD_LD;
                        r_ras_cnt[w_idx]   <= RAS_LD;
                    end
                    OP_PRE: begin
                        // PRE to an idle bank is a no-op and does not restart tRP.
                        if (w_open) begin
                            r_bank_open[w_idx] <= 1'b0;
                            r_rp_cnt[w_idx]    <= RP_LD;
                        end
                    end
                    OP_REF: begin
                        r_rfc_cnt    <= RFC_LD;
                        r_refreshing <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_valid                      = r_pipe_vld[T_CAS-1];
    assign {o_rd_bg, o_rd_bank, o_rd_col}  = r_pipe_dat[T_CAS-1];
    assign o_viol                          = r_viol;
    assign o_viol_code                     = r_viol_code;
    assign o_bank_open                     = r_bank_open;
    assign o_refreshing                    = r_refreshing;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder: each task drives one scenario and checks hand-computed expectations.
module tb_dram_cmd_responder;

    localparam logic [2:0] RD = 3'd0, WR = 3'd1, ACT = 3'd2, PRE = 3'd3, REF = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [1:0]  cmd_bg = 2'd0;
    logic [1:0]  cmd_bank = 2'd0;
    logic [14:0] cmd_row = 15'd0;
    logic [9:0]  cmd_col = 10'd0;
    logic        rd_valid;
    logic [1:0]  rd_bg;
    logic [1:0]  rd_bank;
    logic [9:0]  rd_col;
    logic        viol;
    logic [3:0]  viol_code;
    logic [15:0] bank_open;
    logic        refreshing;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dram_cmd_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd_op     (cmd_op),
        .i_cmd_bg     (cmd_bg),
        .i_cmd_bank   (cmd_bank),
        .i_cmd_row    (cmd_row),
        .i_cmd_col    (cmd_col),
        .o_rd_valid   (rd_valid),
        .o_rd_bg      (rd_bg),
        .o_rd_bank    (rd_bank),
        .o_rd_col     (rd_col),
        .o_viol       (viol),
        .o_viol_code  (viol_code),
        .o_bank_open  (bank_open),
        .o_refreshing (refreshing)
    );

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for a single cycle; returns one cycle later, when viol for it is visible.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] bg, input logic [1:0] bank,
                          input logic [14:0] row, input logic [9:0] col);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_bg    = bg;
        cmd_bank  = bank;
        cmd_row   = row;
        cmd_col   = col;
        idle(1);
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        vec++;
        if (bank_open !== 16'h0 || viol !== 1'b0 || viol_code !== 4'd0 || rd_valid !== 1'b0 ||
            refreshing !== 1'b0 || rd_col !== 10'd0) begin
            errs++;
            $display("FAIL reset_state: open=%h viol=%b code=%0d rdv=%b ref=%b col=%0d, want all 0",
                     bank_open, viol, viol_code, rd_valid, refreshing, rd_col);
        end
    endtask

    task automatic test_act_rd;
        apply_reset();
        do_cmd(ACT, 2'd0, 2'd0, 15'd5, 10'd0);
        vec++;
        if (viol !== 1'b0 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL act_open: viol=%b open=%h, want 0/0001", viol, bank_open);
        end
        idle(23);
        do_cmd(RD, 2'd0, 2'd0, 15'd5, 10'd3);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL rd_at_trcd: viol=%b code=%0d, want 0", viol, viol_code);
        end
        idle(22);
        vec++;
        if (rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL rd_early: rd_valid=%b at RD+23, want 0", rd_valid);
        end
        idle(1);
        vec++;
        if (rd_valid !== 1'b1 || rd_bg !== 2'd0 || rd_bank !== 2'd0 || rd_col !== 10'd3) begin
            errs++;
            $display("FAIL rd_return: v=%b bg=%0d bank=%0d col=%0d, want 1/0/0/3", rd_valid, rd_bg, rd_bank, rd_col);
        end
        idle(1);
        vec++;
        if (rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL rd_pulse_width: rd_valid=%b at RD+25, want 0", rd_valid);
        end
    endtask

    task automatic test_trcd;
        int pulses;
        int seen_at;
        logic [9:0] seen_col;
        apply_reset();
        do_cmd(ACT, 2'd0, 2'd0, 15'd5, 10'd0);
        idle(22);
        do_cmd(RD, 2'd0, 2'd0, 15'd5, 10'd7);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd3) begin
            errs++;
            $display("FAIL trcd_early: viol=%b code=%0d, want 1/3", viol, viol_code);
        end
        do_cmd(RD, 2'd0, 2'd0, 15'd5, 10'd9);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL trcd_exact: viol=%b code=%0d, want 0", viol, viol_code);
        end
        pulses = 0;
        seen_at = 0;
        seen_col = 10'd0;
        for (int i = 2; i <= 32; i++) begin
            idle(1);
            if (rd_valid === 1'b1) begin
                pulses++;
                seen_at = i;
                seen_col = rd_col;
            end
        end
        vec++;
        if (pulses != 1 || seen_at != 24 || seen_col !== 10'd9) begin
            errs++;
            $display("FAIL trcd_returns: pulses=%0d at RD+%0d col=%0d, want 1 at RD+24 col 9", pulses, seen_at, seen_col);
        end
    endtask

    task automatic test_ccd;
        apply_reset();
        do_cmd(ACT, 2'd0, 2'd0, 15'd1, 10'd0);
        do_cmd(ACT, 2'd0, 2'd1, 15'd2, 10'd0);
        do_cmd(ACT, 2'd1, 2'd0, 15'd3, 10'd0);
        idle(23);
        do_cmd(RD, 2'd0, 2'd0, 15'd1, 10'd1);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL ccd_first: viol=%b code=%0d, want 0", viol, viol_code);
        end
        idle(3);
        do_cmd(RD, 2'd0, 2'd1, 15'd2, 10'd2);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd4) begin
            errs++;
            $display("FAIL ccd_l_same_bg: viol=%b code=%0d, want 1/4", viol, viol_code);
        end
        idle(30);
        do_cmd(RD, 2'd0, 2'd0, 15'd1, 10'd10);
        idle(3);
        do_cmd(RD, 2'd1, 2'd0, 15'd3, 10'd11);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL ccd_s_diff_bg: viol=%b code=%0d, want 0", viol, viol_code);
        end
        idle(19);
        vec++;
        if (rd_valid !== 1'b1 || rd_bg !== 2'd0 || rd_col !== 10'd10) begin
            errs++;
            $display("FAIL ccd_ret_a: v=%b bg=%0d col=%0d, want 1/0/10", rd_valid, rd_bg, rd_col);
        end
        idle(1);
        vec++;
        if (rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL ccd_gap: rd_valid=%b between returns, want 0", rd_valid);
        end
        idle(3);
        vec++;
        if (rd_valid !== 1'b1 || rd_bg !== 2'd1 || rd_col !== 10'd11) begin
            errs++;
            $display("FAIL ccd_ret_b: v=%b bg=%0d col=%0d, want 1/1/11", rd_valid, rd_bg, rd_col);
        end
    endtask

    task automatic test_ras_rp;
        apply_reset();
        do_cmd(ACT, 2'd0, 2'd0, 15'd5, 10'd0);
        idle(50);
        do_cmd(PRE, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd6 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL tras_early: viol=%b code=%0d open=%h, want 1/6/0001", viol, viol_code, bank_open);
        end
        do_cmd(PRE, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b0 || bank_open !== 16'h0000) begin
            errs++;
            $display("FAIL tras_exact: viol=%b open=%h, want 0/0000", viol, bank_open);
        end
        idle(22);
        do_cmd(ACT, 2'd0, 2'd0, 15'd6, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd5 || bank_open !== 16'h0000) begin
            errs++;
            $display("FAIL trp_early: viol=%b code=%0d open=%h, want 1/5/0000", viol, viol_code, bank_open);
        end
        do_cmd(ACT, 2'd0, 2'd0, 15'd6, 10'd0);
        vec++;
        if (viol !== 1'b0 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL trp_exact: viol=%b open=%h, want 0/0001", viol, bank_open);
        end
        do_cmd(PRE, 2'd3, 2'd3, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b0 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL pre_idle_noop: viol=%b open=%h, want 0/0001", viol, bank_open);
        end
    endtask

    task automatic test_codes;
        int stray;
        apply_reset();
        do_cmd(RD, 2'd2, 2'd1, 15'd7, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd1) begin
            errs++;
            $display("FAIL rd_idle_bank: viol=%b code=%0d, want 1/1", viol, viol_code);
        end
        do_cmd(ACT, 2'd2, 2'd1, 15'd7, 10'd0);
        idle(22);
        do_cmd(RD, 2'd2, 2'd1, 15'd8, 10'd4);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd2) begin
            errs++;
            $display("FAIL row_mismatch: viol=%b code=%0d, want 1/2", viol, viol_code);
        end
        do_cmd(WR, 2'd2, 2'd1, 15'd7, 10'd4);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL wr_legal: viol=%b code=%0d, want 0", viol, viol_code);
        end
        do_cmd(3'd5, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd9) begin
            errs++;
            $display("FAIL illegal_op: viol=%b code=%0d, want 1/9", viol, viol_code);
        end
        do_cmd(ACT, 2'd2, 2'd1, 15'd9, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd8) begin
            errs++;
            $display("FAIL act_active: viol=%b code=%0d, want 1/8", viol, viol_code);
        end
        idle(1);
        vec++;
        if (viol !== 1'b0) begin
            errs++;
            $display("FAIL viol_pulse_width: viol=%b, want 0", viol);
        end
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            if (rd_valid === 1'b1) stray++;
        end
        vec++;
        if (stray != 0) begin
            errs++;
            $display("FAIL wr_no_return: rd_valid pulses=%0d, want 0", stray);
        end
    endtask

    task automatic test_refresh;
        apply_reset();
        do_cmd(ACT, 2'd1, 2'd2, 15'd4, 10'd0);
        vec++;
        if (bank_open !== 16'h0040) begin
            errs++;
            $display("FAIL ref_act_open: open=%h, want 0040", bank_open);
        end
        do_cmd(REF, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd7 || refreshing !== 1'b0) begin
            errs++;
            $display("FAIL ref_bank_open: viol=%b code=%0d ref=%b, want 1/7/0", viol, viol_code, refreshing);
        end
        idle(50);
        do_cmd(PRE, 2'd1, 2'd2, 15'd0, 10'd0);
        idle(22);
        do_cmd(REF, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd7) begin
            errs++;
            $display("FAIL ref_trp_pending: viol=%b code=%0d, want 1/7", viol, viol_code);
        end
        do_cmd(REF, 2'd0, 2'd0, 15'd0, 10'd0);
        vec++;
        if (viol !== 1'b0 || refreshing !== 1'b1) begin
            errs++;
            $display("FAIL ref_accept: viol=%b ref=%b, want 0/1", viol, refreshing);
        end
        idle(99);
        do_cmd(ACT, 2'd0, 2'd0, 15'd1, 10'd0);
        vec++;
        if (viol !== 1'b1 || viol_code !== 4'd7 || bank_open !== 16'h0000) begin
            errs++;
            $display("FAIL act_in_trfc: viol=%b code=%0d open=%h, want 1/7/0000", viol, viol_code, bank_open);
        end
        idle(249);
        vec++;
        if (refreshing !== 1'b1) begin
            errs++;
            $display("FAIL trfc_last_cycle: refreshing=%b at REF+350, want 1", refreshing);
        end
        do_cmd(ACT, 2'd0, 2'd0, 15'd1, 10'd0);
        vec++;
        if (viol !== 1'b0 || refreshing !== 1'b0 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL act_after_trfc: viol=%b ref=%b open=%h, want 0/0/0001", viol, refreshing, bank_open);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        apply_reset();
        do_cmd(ACT, 2'd0, 2'd0, 15'd2, 10'd0);
        idle(23);
        do_cmd(RD, 2'd0, 2'd0, 15'd2, 10'd5);
        idle(9);
        rst_n = 1'b0;
        #1;
        vec++;
        if (bank_open !== 16'h0 || viol !== 1'b0 || rd_valid !== 1'b0 || refreshing !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_async: open=%h viol=%b rdv=%b ref=%b, want all 0", bank_open, viol, rd_valid, refreshing);
        end
        idle(2);
        rst_n = 1'b1;
        do_cmd(ACT, 2'd0, 2'd0, 15'd3, 10'd0);
        vec++;
        if (viol !== 1'b0 || bank_open !== 16'h0001) begin
            errs++;
            $display("FAIL act_after_reset: viol=%b code=%0d open=%h, want 0/0001", viol, viol_code, bank_open);
        end
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            idle(1);
            if (rd_valid === 1'b1) stray++;
        end
        vec++;
        if (stray != 0) begin
            errs++;
            $display("FAIL flushed_read: rd_valid pulses=%0d, want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_act_rd();
        test_trcd();
        test_ccd();
        test_ras_rp();
        test_codes();
        test_refresh();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
